pipe_ctrl_chain: RTL and testbench

- Parametrised pipeline-register chain with per-stage valid bits, backward-propagating stall, partial flush (rollback) and a valid/ready boundary at both ends.
- Successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers, which have no valid bits and only whole-register clear.
- Sits between the datapath stages of the next core; the datapath reads per-stage payload and valid bits from this block.

---
 rtl/pipe_ctrl_chain_pkg.sv | 16 +
 rtl/pipe_stage_reg.sv | 40 ++++
 rtl/pipe_ctrl_chain.sv | 121 ++++++++++++
 tb/tb_pipe_ctrl_chain.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_chain_pkg.sv
// Shared definitions for pipe_ctrl_chain: stage ordering, count-field width and flush saturation.
package pipe_ctrl_chain_pkg;

  // Stage 0 is the youngest (input side); stage STAGES-1 is the oldest (output side).
  localparam int YOUNGEST_STAGE = 0;

  function automatic int calc_cnt_w(input int stages);
    return $clog2(stages + 1);
  endfunction

  // A rollback can never kill more stages than exist.
  function automatic int sat_flush(input int cnt, input int stages);
    return (cnt > stages) ? stages : cnt;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage: payload register plus valid flop with kill priority over load.
module pipe_stage_reg
  import pipe_ctrl_chain_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             kill,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_reg;
  logic [WIDTH-1:0] data_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
    end else if (kill) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= prev_valid;
    end
  end

  // Payload is deliberately left out of reset; only the valid bit qualifies it.
  always_ff @(posedge clk) begin
    if (load) begin
      data_reg <= prev_data;
    end
  end

  assign valid = valid_reg;
  assign data  = data_reg;

endmodule

// File: rtl/pipe_ctrl_chain.sv
// Valid-tracked pipeline register chain with backward stall, rollback flush and ready/valid ends.
// Define PIPE_BUBBLE_COLLAPSE_EN to let empty stages keep accepting behind a stall.
module pipe_ctrl_chain
  import pipe_ctrl_chain_pkg::*;
#(
  parameter int STAGES = 4,
  parameter int WIDTH  = 64,
  parameter int CNT_W  = calc_cnt_w(STAGES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        in_data,
  output logic                    in_ready,
  input  logic [STAGES-1:0]       stall_req,
  input  logic                    flush_req,
  input  logic [CNT_W-1:0]        flush_cnt,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  input  logic                    out_ready,
  output logic [STAGES-1:0]       stage_valid,
  output logic [STAGES*WIDTH-1:0] stage_data,
  output logic [CNT_W-1:0]        occupancy
);

  logic [STAGES-1:0] valid_reg;
  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] kill;
  logic [STAGES-1:0] valid_in;
  logic [STAGES-1:0] valid_next;
  logic [WIDTH-1:0]  data_reg [STAGES];
  logic [CNT_W-1:0]  flush_k;
  logic [CNT_W-1:0]  occupancy_reg;
  logic [CNT_W-1:0]  occupancy_next;
  logic              hold_chain;

  assign flush_k = CNT_W'(sat_flush(int'(flush_cnt), STAGES));

  // Hold ripples from the output end back toward the input.
  always_comb begin
    hold       = '0;
    hold_chain = valid_reg[STAGES-1] & ~out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
`ifdef PIPE_BUBBLE_COLLAPSE_EN
      hold[i] = valid_reg[i] & (stall_req[i] | hold_chain);
`else
      hold[i] = stall_req[i] | hold_chain;
`endif
      hold_chain = hold[i];
    end
  end

  assign load     = ~hold;
  assign in_ready = ~hold[0] & rst_n;

  // Killed stages also mask whatever they would hand to the next stage.
  always_comb begin
    kill     = '0;
    valid_in = '0;
    for (int i = 0; i < STAGES; i++) begin
      kill[i] = flush_req && (CNT_W'(i) < flush_k);
    end
    valid_in[0] = in_valid & ~kill[0];
    for (int i = 1; i < STAGES; i++) begin
      valid_in[i] = valid_reg[i-1] & ~hold[i-1] & ~kill[i-1];
    end
  end

  always_comb begin
    valid_next = '0;
    if (rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        valid_next[i] = kill[i] ? 1'b0 : (hold[i] ? valid_reg[i] : valid_in[i]);
      end
    end
  end

  assign occupancy_next = CNT_W'($countones(valid_next));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occupancy_reg <= '0;
    end else begin
      occupancy_reg <= occupancy_next;
    end
  end

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [WIDTH-1:0] prev_data;

      if (gi == YOUNGEST_STAGE) begin : g_head
        assign prev_data = in_data;
      end else begin : g_link
        assign prev_data = data_reg[gi-1];
      end

      pipe_stage_reg #(
        .WIDTH(WIDTH)
      ) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load[gi]),
        .kill      (kill[gi]),
        .prev_valid(valid_in[gi]),
        .prev_data (prev_data),
        .valid     (valid_reg[gi]),
        .data      (data_reg[gi])
      );

      assign stage_data[gi*WIDTH +: WIDTH] = data_reg[gi];
    end
  endgenerate

  assign out_valid   = valid_reg[STAGES-1];
  assign out_data    = data_reg[STAGES-1];
  assign stage_valid = valid_reg;
  assign occupancy   = occupancy_reg;

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Scoreboard bench for pipe_ctrl_chain: slot-array reference model, directed scenarios, random traffic.
module tb_pipe_ctrl_chain;
  localparam int S  = 4;
  localparam int W  = 32;
  localparam int CW = $clog2(S + 1);

  logic           clk = 1'b0;
  logic           rst_n, in_valid, in_ready, flush_req, out_valid, out_ready;
  logic [W-1:0]   in_data, out_data;
  logic [S-1:0]   stall_req, stage_valid;
  logic [CW-1:0]  flush_cnt, occupancy;
  logic [S*W-1:0] stage_data;

  int           checks = 0;
  int           failures = 0;
  int           peak_occ = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;

  // Reference slots: item presence and payload per stage, index 0 youngest.
  bit           mv[S];
  logic [W-1:0] md[S];
  bit           held[S];

  always #5 clk = ~clk;

  pipe_ctrl_chain #(.STAGES(S), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .stall_req(stall_req), .flush_req(flush_req), .flush_cnt(flush_cnt),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .stage_valid(stage_valid), .stage_data(stage_data), .occupancy(occupancy)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // A slot stays put when something at or beyond it blocks the path to the consumer.
  task automatic model_hold(input logic [S-1:0] st, input bit orr);
    for (int i = 0; i < S; i++) begin
      held[i] = 1'b0;
`ifdef PIPE_BUBBLE_COLLAPSE_EN
      for (int j = i; j < S; j++) begin
        if (!mv[j]) break;
        if (st[j] || (j == S - 1 && !orr)) begin
          held[i] = 1'b1;
          break;
        end
      end
`else
      if (mv[S-1] && !orr) held[i] = 1'b1;
      for (int j = i; j < S; j++) if (st[j]) held[i] = 1'b1;
`endif
    end
  endtask

  task automatic step(input bit rn, input bit iv, input logic [W-1:0] id, input logic [S-1:0] st,
                      input bit fr, input int fc, input bit orr);
    bit           nv[S];
    logic [W-1:0] nd[S];
    logic [S-1:0] vexp;
    int           k, occ;
    rst_n = rn; in_valid = iv; in_data = id; stall_req = st;
    flush_req = fr; flush_cnt = CW'(fc); out_ready = orr;
    model_hold(st, orr);
    if (rn && mv[S-1] && orr) exp_q.push_back(md[S-1]);
    #1;
    chk("in_ready", in_ready, rn && !held[0]);
    k = (fc > S) ? S : fc;
    for (int i = 0; i < S; i++) begin
      if (held[i]) begin
        nv[i] = mv[i]; nd[i] = md[i];
      end else if (i == 0) begin
        nv[i] = iv; nd[i] = id;
      end else begin
        nv[i] = mv[i-1] && !held[i-1]; nd[i] = md[i-1];
      end
    end
    if (fr) begin
      for (int i = 0; i < k; i++) nv[i] = 1'b0;
      if (k >= 1 && k < S && !held[k]) nv[k] = 1'b0;
    end
    if (!rn) for (int i = 0; i < S; i++) nv[i] = 1'b0;
    @(posedge clk);
    #1;
    occ = 0;
    vexp = '0;
    for (int i = 0; i < S; i++) begin
      mv[i] = nv[i]; md[i] = nd[i];
      vexp[i] = nv[i];
      occ += int'(nv[i]);
    end
    chk("stage_valid", stage_valid, vexp);
    chk("occupancy", occupancy, occ);
    for (int i = 0; i < S; i++) if (nv[i]) chk("stage_data", stage_data[i*W +: W], nd[i]);
    if (int'(occupancy) > peak_occ) peak_occ = int'(occupancy);
  endtask

  // Monitor: every output handshake must match the next expected item.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL out_unexpected: got=%0h expected=none at %0t", out_data, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_data !== mon_exp) begin
          failures++;
          $display("FAIL out_data: got=%0h expected=%0h at %0t", out_data, mon_exp, $time);
        end else begin
          $display("out handshake data=%0h at %0t", out_data, $time);
        end
      end
    end
  end

  initial begin
    logic [S-1:0] st;
    for (int i = 0; i < S; i++) begin mv[i] = 1'b0; md[i] = '0; end
    repeat (2) step(0, 0, 0, 0, 0, 0, 1);

    // Streaming
    peak_occ = 0;
    for (int n = 0; n < 8; n++) step(1, 1, 32'h10 + n, 0, 0, 0, 1);
    repeat (5) step(1, 0, 0, 0, 0, 0, 1);
    chk("stream_peak_occ", peak_occ, 4);

    // Backpressure
    for (int n = 0; n < 4; n++) step(1, 1, 32'hA0 + n, 0, 0, 0, 1);
    for (int n = 0; n < 3; n++) step(1, 1, 32'hB0 + n, 0, 0, 0, 0);
    chk("bp_in_ready", in_ready, 0);
    for (int n = 0; n < 6; n++) step(1, 0, 0, 0, 0, 0, 1);

    // Mid-pipe stall
    for (int n = 0; n < 5; n++) step(1, 1, 32'hC0 + n, 0, 0, 0, 1);
    step(1, 1, 32'hC5, 4'b0010, 0, 0, 1);
    for (int n = 0; n < 3; n++) step(1, 1, 32'hC6 + n, 0, 0, 0, 1);
    repeat (5) step(1, 0, 0, 0, 0, 0, 1);

    // Partial flush of the two youngest stages
    for (int n = 0; n < 4; n++) step(1, 1, 32'hD0 + n, 0, 0, 0, 0);
    step(1, 1, 32'hE0, 0, 1, 2, 0);
    chk("flush_partial_valid", stage_valid, 4'b1100);
    repeat (4) step(1, 0, 0, 0, 0, 0, 1);

    // Saturated flush under backpressure
    for (int n = 0; n < 4; n++) step(1, 1, 32'hF0 + n, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 7, 0);
    chk("sat_valid", stage_valid, 0);
    chk("sat_occ", occupancy, 0);
    chk("sat_out_valid", out_valid, 0);

    // Reset mid-run
    for (int n = 0; n < 3; n++) step(1, 1, 32'h70 + n, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("rst_valid", stage_valid, 0);
    chk("rst_occ", occupancy, 0);
    step(1, 0, 0, 0, 0, 0, 1);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      for (int b = 0; b < S; b++) st[b] = ($urandom_range(0, 7) == 0);
      step($urandom_range(0, 63) != 0, $urandom_range(0, 9) < 7, $urandom, st,
           $urandom_range(0, 15) == 0, $urandom_range(0, 7), $urandom_range(0, 3) != 0);
    end
    repeat (6) step(1, 0, 0, 0, 0, 0, 1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
